// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter sharing the register file write port, x0 writes dropped
module reg_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit HIPRI_P0 = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      STALL,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic                      WB_WRITE_EN,
    output logic [ADDR_W-1:0]         WB_ADDR,
    output logic [DATA_W-1:0]         WB_DATA,
    output logic [31:0]               PENDING,
    output logic [7:0]                DROP_CNT
);
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0] ptr, gnt_idx, idx;
    logic gnt_any, gnt_hp, wr;
    logic [ADDR_W-1:0] addr_a [NUM_REQ];
    logic [DATA_W-1:0] data_a [NUM_REQ];
    genvar i;
    generate
        for (i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign addr_a[i] = REQ_ADDR[i*ADDR_W +: ADDR_W];
            assign data_a[i] = REQ_DATA[i*DATA_W +: DATA_W];
        end
    endgenerate
    // descending scan so the last hit is the first valid port at or after ptr
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        gnt_hp = 1'b0;
        idx = '0;
        if (RESET && !STALL) begin
            if (HIPRI_P0 && REQ_VALID[0]) begin
                gnt_any = 1'b1;
                gnt_hp = 1'b1;
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    idx = PW'((int'(ptr) + k) % NUM_REQ);
                    if (REQ_VALID[idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = idx;
                    end
                end
            end
        end
    end
    assign REQ_READY = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign wr = gnt_any && addr_a[gnt_idx] != '0;
    assign PENDING = WB_WRITE_EN ? (32'd1 << WB_ADDR) : '0;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr <= '0;
            WB_WRITE_EN <= 1'b0;
            WB_ADDR <= '0;
            WB_DATA <= '0;
            DROP_CNT <= '0;
        end else begin
            WB_WRITE_EN <= wr;
            if (wr) begin
                WB_ADDR <= addr_a[gnt_idx];
                WB_DATA <= data_a[gnt_idx];
            end
            if (gnt_any && !wr && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
            if (gnt_any && !gnt_hp) ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: random and directed checks of a round-robin and a priority instance against a model
module tb_reg_wb_arbiter;
    localparam int N = 4, AW = 5, DW = 32;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic RESET, STALL;
    logic [N-1:0] vld [2];
    logic [N*AW-1:0] adr [2];
    logic [N*DW-1:0] dat [2];
    logic [N-1:0] rdy [2];
    logic we [2];
    logic [AW-1:0] wa [2];
    logic [DW-1:0] wd [2];
    logic [31:0] pend [2];
    logic [7:0] drop [2];
    int errors = 0, checks = 0;
    bit checking = 1'b0;
    int ptr [2], e_wa [2], e_drop [2], cur_gnt [2];
    bit e_we [2];
    logic [DW-1:0] e_wd [2];
    int mg, ma;

    reg_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .HIPRI_P0(1'b0)) u_rr (
        .CLK(clk), .RESET(RESET), .STALL(STALL), .REQ_VALID(vld[0]), .REQ_ADDR(adr[0]),
        .REQ_DATA(dat[0]), .REQ_READY(rdy[0]), .WB_WRITE_EN(we[0]), .WB_ADDR(wa[0]),
        .WB_DATA(wd[0]), .PENDING(pend[0]), .DROP_CNT(drop[0]));
    reg_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .HIPRI_P0(1'b1)) u_hp (
        .CLK(clk), .RESET(RESET), .STALL(STALL), .REQ_VALID(vld[1]), .REQ_ADDR(adr[1]),
        .REQ_DATA(dat[1]), .REQ_READY(rdy[1]), .WB_WRITE_EN(we[1]), .WB_ADDR(wa[1]),
        .WB_DATA(wd[1]), .PENDING(pend[1]), .DROP_CNT(drop[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int grant(input int m);
        if (!RESET || STALL) return -1;
        if (m == 1 && vld[1][0]) return 0;
        for (int k = 0; k < N; k++) if (vld[m][(ptr[m] + k) % N]) return (ptr[m] + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            cur_gnt[m] = grant(m);
            if (checking) begin
                chk($sformatf("ready%0d", m), rdy[m], cur_gnt[m] < 0 ? 64'd0 : 64'd1 << cur_gnt[m]);
                chk($sformatf("we%0d", m), we[m], e_we[m]);
                chk($sformatf("addr%0d", m), wa[m], e_wa[m]);
                chk($sformatf("data%0d", m), wd[m], e_wd[m]);
                chk($sformatf("pending%0d", m), pend[m], e_we[m] ? 64'd1 << e_wa[m] : 64'd0);
                chk($sformatf("drop%0d", m), drop[m], e_drop[m]);
            end
        end
    end

    always @(posedge clk or negedge RESET) begin
        for (int m = 0; m < 2; m++) begin
            if (!RESET) begin
                ptr[m] = 0; e_we[m] = 0; e_wa[m] = 0; e_wd[m] = '0; e_drop[m] = 0;
            end else begin
                mg = cur_gnt[m];
                e_we[m] = 0;
                if (mg >= 0) begin
                    ma = int'(adr[m][mg*AW +: AW]);
                    if (ma != 0) begin
                        e_we[m] = 1; e_wa[m] = ma; e_wd[m] = dat[m][mg*DW +: DW];
                    end else if (e_drop[m] < 255) e_drop[m]++;
                    if (!(m == 1 && mg == 0)) ptr[m] = (mg + 1) % N;
                end
            end
        end
    end

    initial begin
        RESET = 1'b0; STALL = 1'b0;
        vld = '{default: '0}; adr = '{default: '0}; dat = '{default: '0};
        repeat (3) @(posedge clk);
        #1 RESET = 1'b1; checking = 1'b1;
        for (int m = 0; m < 2; m++) begin
            vld[m] = 4'b0100; adr[m][2*AW +: AW] = 5; dat[m][2*DW +: DW] = 32'hDEADBEEF;
        end
        #1 chk("t2_ready", rdy[0], 4'b0100);
        @(posedge clk); #1 vld[0] = '0; vld[1] = '0;
        #1 chk("t2_we", we[0], 1); chk("t2_addr", wa[0], 5);
        chk("t2_data", wd[0], 32'hDEADBEEF); chk("t2_pend", pend[0], 32'h20);
        RESET = 1'b0;
        #1 chk("t1_we", we[0], 0); chk("t1_addr", wa[0], 0); chk("t1_data", wd[0], 0);
        chk("t1_pend", pend[0], 0); chk("t1_drop", drop[0], 0);
        @(posedge clk); #1 RESET = 1'b1;
        vld[0] = 4'hF; vld[1] = 4'b0011;
        for (int i = 0; i < N; i++) begin
            adr[0][i*AW +: AW] = AW'(i + 1); dat[0][i*DW +: DW] = 32'h100 + i;
        end
        adr[1] = adr[0]; dat[1] = dat[0];
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_ready", rdy[0], 64'd1 << (k % 4)); chk("t4_ready", rdy[1], 1);
            @(posedge clk); #1 chk("t3_we", we[0], 1); chk("t3_addr", wa[0], k % 4 + 1);
        end
        vld[0] = '0; vld[1] = 4'b0010;
        #1 chk("t4_p1", rdy[1], 2);
        @(posedge clk); #1 vld[1] = '0;
        #1 chk("t4_addr", wa[1], 2);
        vld[0] = 4'hF; STALL = 1'b1;
        repeat (4) begin
            #1 chk("t6_ready", rdy[0], 0);
            @(posedge clk); #1 chk("t6_we", we[0], 0);
        end
        STALL = 1'b0;
        #1 chk("t6_resume", rdy[0], 4'b0010);
        @(posedge clk); #1 vld[0] = 4'b0010; adr[0][AW +: AW] = '0;
        repeat (3) begin
            #1 chk("t5_ready", rdy[0], 4'b0010);
            @(posedge clk); #1 chk("t5_we", we[0], 0);
        end
        chk("t5_drop3", drop[0], 3);
        repeat (297) @(posedge clk);
        #1 chk("t5_sat", drop[0], 255);
        vld[0] = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            RESET = (c % 1000 != 999);
            STALL = ($urandom_range(0, 7) == 0);
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    if (vld[m][i] && cur_gnt[m] != i) begin
                        if ($urandom_range(0, 15) == 0) vld[m][i] = 1'b0;
                    end else begin
                        vld[m][i] = $urandom_range(0, 1) == 1;
                        adr[m][i*AW +: AW] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
                        dat[m][i*DW +: DW] = $urandom;
                    end
                end
            end
        end
        @(posedge clk); #1 vld = '{default: '0}; RESET = 1'b1;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
